// File: rtl/regfile_arb.sv
// regfile_arb: two-requester arbiter in front of eight external 8-bit registers
// Ports: clk, reset (sync, active-high); a_*/b_* request/we/addr/wdata in, ack/rdata out;
//        reg_en/reg_d drive the register writes, reg_q returns their contents; busy in ACCESS/DONE.
// Build option: define RR_ARB_EN for round-robin conflict resolution; otherwise A has fixed priority.
module regfile_arb (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [2:0]  a_addr,
    input  logic [7:0]  a_wdata,
    output logic        a_ack,
    output logic [7:0]  a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [2:0]  b_addr,
    input  logic [7:0]  b_wdata,
    output logic        b_ack,
    output logic [7:0]  b_rdata,
    output logic [7:0]  reg_en,
    output logic [7:0]  reg_d,
    input  logic [63:0] reg_q,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t state, state_nxt;
    logic       grant_b, start, l_b, l_we;
    logic [2:0] l_addr;
    logic [7:0] l_wdata, rd_val;
    assign start = state == IDLE && (a_req || b_req);
`ifdef RR_ARB_EN
    logic last_b;
    assign grant_b = b_req && (!a_req || !last_b);
    always_ff @(posedge clk)
        if (reset) last_b <= 1'b1;
        else if (start) last_b <= grant_b;
`else
    assign grant_b = b_req && !a_req;
`endif
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = start ? ACCESS : IDLE;
            ACCESS:  state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk)
        state <= reset ? IDLE : state_nxt;
    always_ff @(posedge clk)
        if (start) begin
            l_b     <= grant_b;
            l_we    <= grant_b ? b_we : a_we;
            l_addr  <= grant_b ? b_addr : a_addr;
            l_wdata <= grant_b ? b_wdata : a_wdata;
        end
    // reg_d is loaded only when a write is granted so it holds through reads and idle
    always_ff @(posedge clk)
        if (reset) reg_d <= 8'h00;
        else if (start && (grant_b ? b_we : a_we)) reg_d <= grant_b ? b_wdata : a_wdata;
    assign rd_val = l_we ? l_wdata : reg_q[8*l_addr +: 8];
    always_ff @(posedge clk)
        if (reset) begin
            a_rdata <= 8'h00;
            b_rdata <= 8'h00;
        end else if (state == ACCESS) begin
            if (l_b) b_rdata <= rd_val;
            else a_rdata <= rd_val;
        end
    // decoded from state so a reset in ACCESS still presents the write and a reset in DONE keeps the ack
    assign reg_en = (state == ACCESS && l_we) ? 8'h01 << l_addr : 8'h00;
    assign a_ack  = state == DONE && !l_b;
    assign b_ack  = state == DONE && l_b;
    assign busy   = state != IDLE;
endmodule
